hdmi_line_reader: RTL and testbench

Pixel-side consumer of the HDMI line buffer (4096 × 32-bit read port, one-cycle read latency, unregistered output). It runs in the read clock domain. It requests lines from the upstream DDR fetch logic into two ping-pong halves of the buffer. It then generates buffer read addresses under the display timing generator's data-enable and emits buffer data aligned to delayed sync/DE.

---
 rtl/hdmi_line_reader_if.sv | 23 ++
 rtl/hdmi_line_reader.sv | 145 ++++++++++++++
 tb/tb_hdmi_line_reader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_line_reader_if.sv
// Line-request handshake and line-buffer read port between hdmi_line_reader
// (master) and the DDR fetch logic / buffer RAM (slave).
interface hdmi_line_reader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  line_req;
  logic                  line_req_half;
  logic [11:0]           line_req_num;
  logic                  line_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output line_req, line_req_half, line_req_num, rd_addr,
    input  line_ready, rd_data
  );

  modport slave (
    input  line_req, line_req_half, line_req_num, rd_addr,
    output line_ready, rd_data
  );
endinterface

// File: rtl/hdmi_line_reader.sv
// Pixel-side reader of the ping-pong HDMI line buffer: prefetches lines from
// upstream and streams buffer words aligned to a 2-cycle delayed sync/DE.
module hdmi_line_reader #(
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  vs_in,
  input  logic                  hs_in,
  input  logic                  de_in,
  hdmi_line_reader_if.master    bus,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  de_out,
  output logic                  hs_out,
  output logic                  vs_out,
  output logic                  underflow
);

  // One bit wider than the in-half offset so col can saturate at H_ACTIVE = 2048.
  localparam int COL_W = ADDR_WIDTH;

  typedef enum logic {IDLE, LINE} rd_state_t;

  rd_state_t        state;
  logic             vs_d, de_d, hs_d, vs_p;
  logic             armed;
  logic [1:0]       half_valid, hv_nxt;
  logic             wr_half, wr_eff;
  logic             rd_half, rd_half_nxt;
  logic             req_pend, req_go, rdy_take;
  logic [11:0]      req_cnt;
  logic [COL_W-1:0] col, col_nxt, col_sat;
  logic             col_in_range;
  logic             line_ok, samp_valid, samp_d;
  logic             vs_rise, de_rise, line_start, line_end;

  always_comb begin
    vs_rise      = vs_in & ~vs_d;
    de_rise      = de_in & ~de_d;
    line_start   = (state == IDLE) & de_rise & ~vs_rise;
    line_end     = (state == LINE) & ~de_in & ~vs_rise;
    rdy_take     = bus.line_ready & req_pend;
    col_in_range = col < COL_W'(H_ACTIVE);

    // Line-end clear and line_ready set touch different halves, so both apply.
    hv_nxt = half_valid;
    if (line_end && line_ok) hv_nxt[rd_half] = 1'b0;
    if (rdy_take)            hv_nxt[wr_half] = 1'b1;
    wr_eff = wr_half ^ rdy_take;

    // Evaluated on post-update state so a freed half is re-requested at once.
    req_go = armed & ~vs_in & ~(req_pend & ~rdy_take) & ~hv_nxt[wr_eff]
           & (req_cnt < 12'(V_ACTIVE));

    col_nxt = col;
    if (vs_rise)                                   col_nxt = '0;
    else if (line_start || (state == LINE && de_in)) col_nxt = col_in_range ? col + 1'b1 : col;
    else if (line_end)                             col_nxt = '0;
    col_sat = (col_nxt < COL_W'(H_ACTIVE)) ? col_nxt : COL_W'(H_ACTIVE - 1);

    rd_half_nxt = rd_half;
    if (vs_rise)                    rd_half_nxt = 1'b0;
    else if (line_end && line_ok)   rd_half_nxt = ~rd_half;

    samp_valid = ~vs_rise & col_in_range &
                 (line_start ? half_valid[rd_half] : ((state == LINE) & de_in & line_ok));
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state             <= IDLE;
      vs_d              <= 1'b0;
      de_d              <= 1'b0;
      hs_d              <= 1'b0;
      vs_p              <= 1'b0;
      de_out            <= 1'b0;
      hs_out            <= 1'b0;
      vs_out            <= 1'b0;
      samp_d            <= 1'b0;
      pix_data          <= '0;
      armed             <= 1'b0;
      half_valid        <= '0;
      wr_half           <= 1'b0;
      rd_half           <= 1'b0;
      req_pend          <= 1'b0;
      req_cnt           <= '0;
      col               <= '0;
      line_ok           <= 1'b0;
      underflow         <= 1'b0;
      bus.rd_addr       <= '0;
      bus.line_req      <= 1'b0;
      bus.line_req_half <= 1'b0;
      bus.line_req_num  <= '0;
    end else begin
      vs_d     <= vs_in;
      de_d     <= de_in;
      hs_d     <= hs_in;
      vs_p     <= vs_in;
      de_out   <= de_d;
      hs_out   <= hs_d;
      vs_out   <= vs_p;
      samp_d   <= samp_valid;
      pix_data <= samp_d ? bus.rd_data : '0;

      col          <= col_nxt;
      rd_half      <= rd_half_nxt;
      bus.rd_addr  <= {rd_half_nxt, col_sat[ADDR_WIDTH-2:0]};
      bus.line_req <= 1'b0;

      if (vs_rise) begin
        armed      <= 1'b1;
        half_valid <= '0;
        wr_half    <= 1'b0;
        req_pend   <= 1'b0;
        req_cnt    <= '0;
        underflow  <= 1'b0;
        line_ok    <= 1'b0;
        state      <= IDLE;
      end else begin
        half_valid <= hv_nxt;
        wr_half    <= wr_eff;
        req_pend   <= req_go | (req_pend & ~rdy_take);
        if (req_go) begin
          bus.line_req      <= 1'b1;
          bus.line_req_half <= wr_eff;
          bus.line_req_num  <= req_cnt;
          req_cnt           <= req_cnt + 12'd1;
        end
        case (state)
          IDLE: if (line_start) begin
            state   <= LINE;
            line_ok <= half_valid[rd_half];
            if (!half_valid[rd_half]) underflow <= 1'b1;
          end
          LINE: if (line_end) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdmi_line_reader.sv
// Directed bench: full-size reader (A) for prefetch/pixel stream, small reader
// (H_ACTIVE=8, V_ACTIVE=4) (B) for underflow, collisions, frame end and long DE.
module tb_hdmi_line_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: 1920 x 1080, auto-answering upstream ----------------
  logic vs_a = 0, hs_a = 0, de_a = 0;
  logic [31:0] pix_a;
  logic de_out_a, hs_out_a, vs_out_a, uf_a;
  logic auto_rdy_a = 0;
  logic [31:0] mem_a = 0;
  int cnt_a = 0;
  hdmi_line_reader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus_a ();
  assign bus_a.line_ready = auto_rdy_a;
  assign bus_a.rd_data    = mem_a;
  always @(posedge clk) mem_a <= 32'(bus_a.rd_addr);

  hdmi_line_reader #(.H_ACTIVE(1920), .V_ACTIVE(1080), .ADDR_WIDTH(12), .DATA_WIDTH(32)) dut_a (
    .rd_clk(clk), .rd_rst(rst), .vs_in(vs_a), .hs_in(hs_a), .de_in(de_a), .bus(bus_a),
    .pix_data(pix_a), .de_out(de_out_a), .hs_out(hs_out_a), .vs_out(vs_out_a), .underflow(uf_a));

  always @(posedge clk) begin
    auto_rdy_a <= 1'b0;
    if (bus_a.line_req) cnt_a <= 10;
    else if (cnt_a > 0) begin
      cnt_a <= cnt_a - 1;
      if (cnt_a == 1) auto_rdy_a <= 1'b1;
    end
  end

  // ---------------- DUT B: 8 x 4, manually answered upstream ----------------
  logic vs_b = 0, hs_b = 0, de_b = 0;
  logic [31:0] pix_b;
  logic de_out_b, hs_out_b, vs_out_b, uf_b;
  logic man_rdy_b = 0;
  logic [31:0] mem_b = 0;
  hdmi_line_reader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus_b ();
  assign bus_b.line_ready = man_rdy_b;
  assign bus_b.rd_data    = mem_b;
  always @(posedge clk) mem_b <= 32'(bus_b.rd_addr);

  hdmi_line_reader #(.H_ACTIVE(8), .V_ACTIVE(4), .ADDR_WIDTH(12), .DATA_WIDTH(32)) dut_b (
    .rd_clk(clk), .rd_rst(rst), .vs_in(vs_b), .hs_in(hs_b), .de_in(de_b), .bus(bus_b),
    .pix_data(pix_b), .de_out(de_out_b), .hs_out(hs_out_b), .vs_out(vs_out_b), .underflow(uf_b));

  // ---------------- logs and monitors ----------------
  logic       rq_half_a[$], rq_half_b[$];
  int         rq_num_a[$], rq_num_b[$], rq_cyc_a[$], rdy_cyc_a[$];
  logic [31:0] qa[$], qb[$];
  logic       trk_b = 0;
  int         max_lo_b = 0;

  always @(posedge clk) begin
    if (bus_a.line_req) begin
      rq_half_a.push_back(bus_a.line_req_half);
      rq_num_a.push_back(int'(bus_a.line_req_num));
      rq_cyc_a.push_back(cyc);
    end
    if (bus_a.line_ready) rdy_cyc_a.push_back(cyc);
    if (bus_b.line_req) begin
      rq_half_b.push_back(bus_b.line_req_half);
      rq_num_b.push_back(int'(bus_b.line_req_num));
    end
  end

  always @(negedge clk) begin
    if (de_out_a) qa.push_back(pix_a);
    if (de_out_b) qb.push_back(pix_b);
    if (trk_b && int'(bus_b.rd_addr[10:0]) > max_lo_b) max_lo_b = int'(bus_b.rd_addr[10:0]);
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic pulse_rdy_b();
    man_rdy_b = 1;
    @(negedge clk);
    man_rdy_b = 0;
    @(negedge clk);
  endtask

  task automatic drive_line_b(input int len, input bit rdy_at_fall);
    de_b = 1;
    repeat (len) @(negedge clk);
    de_b = 0;
    man_rdy_b = rdy_at_fall;
    @(negedge clk);
    man_rdy_b = 0;
    repeat (6) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; de_a = 1; hs_a = 1;
    repeat (4) @(negedge clk);
    vectors++; if (bus_a.rd_addr !== 12'd0) begin miscompares++; $display("FAIL rst_rd_addr: got %0h expected 0", bus_a.rd_addr); end
    vectors++; if ({bus_a.line_req, bus_a.line_req_half, bus_a.line_req_num} !== 14'd0) begin miscompares++; $display("FAIL rst_req: got %0h expected 0", {bus_a.line_req, bus_a.line_req_half, bus_a.line_req_num}); end
    vectors++; if ({pix_a, de_out_a, hs_out_a, vs_out_a, uf_a} !== 36'd0) begin miscompares++; $display("FAIL rst_outputs: got %0h expected 0", {pix_a, de_out_a, hs_out_a, vs_out_a, uf_a}); end
    vectors++; if ({pix_b, de_out_b, uf_b, bus_b.rd_addr} !== 46'd0) begin miscompares++; $display("FAIL rst_outputs_b: got %0h expected 0", {pix_b, de_out_b, uf_b, bus_b.rd_addr}); end
    de_a = 0; hs_a = 0;
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    vectors++; if (rq_num_a.size() + rq_num_b.size() != 0) begin miscompares++; $display("FAIL no_req_before_vs: got %0d requests expected 0", rq_num_a.size() + rq_num_b.size()); end
  endtask

  task automatic test_prefetch();
    vs_a = 1;
    @(negedge clk);
    vectors++; if (bus_a.line_req !== 1'b0) begin miscompares++; $display("FAIL req_early: got %b expected 0", bus_a.line_req); end
    vs_a = 0;
    @(negedge clk);
    vectors++; if ({bus_a.line_req, bus_a.line_req_half, bus_a.line_req_num} !== {1'b1, 1'b0, 12'd0}) begin miscompares++; $display("FAIL req0: got %0h expected %0h", {bus_a.line_req, bus_a.line_req_half, bus_a.line_req_num}, {1'b1, 1'b0, 12'd0}); end
    vectors++; if (vs_out_a !== 1'b1) begin miscompares++; $display("FAIL vs_out_delay: got %b expected 1", vs_out_a); end
    @(negedge clk);
    vectors++; if ({bus_a.line_req, vs_out_a} !== 2'b00) begin miscompares++; $display("FAIL req0_pulse: got %b expected 00", {bus_a.line_req, vs_out_a}); end
    repeat (60) @(negedge clk);
    vectors++; if (rq_num_a.size() != 2) begin miscompares++; $display("FAIL prefetch_count: got %0d expected 2", rq_num_a.size()); end
    else begin
      vectors++; if (rq_half_a[1] !== 1'b1 || rq_num_a[1] != 1) begin miscompares++; $display("FAIL req1: got half %b line %0d expected half 1 line 1", rq_half_a[1], rq_num_a[1]); end
      vectors++; if (rdy_cyc_a.size() < 1 || rq_cyc_a[1] - rdy_cyc_a[0] != 1) begin miscompares++; $display("FAIL req1_latency: got %0d expected 1", rdy_cyc_a.size() < 1 ? -1 : rq_cyc_a[1] - rdy_cyc_a[0]); end
    end
  endtask

  task automatic test_hs_delay();
    hs_a = 1;
    @(negedge clk);
    vectors++; if (hs_out_a !== 1'b0) begin miscompares++; $display("FAIL hs_out_d1: got %b expected 0", hs_out_a); end
    hs_a = 0;
    @(negedge clk);
    vectors++; if (hs_out_a !== 1'b1) begin miscompares++; $display("FAIL hs_out_d2: got %b expected 1", hs_out_a); end
    @(negedge clk);
  endtask

  task automatic test_pixel_stream();
    int bad;
    for (int ln = 0; ln < 2; ln++) begin
      qa.delete();
      de_a = 1;
      @(negedge clk);
      vectors++; if (de_out_a !== 1'b0) begin miscompares++; $display("FAIL de_out_d1: got %b expected 0", de_out_a); end
      @(negedge clk);
      vectors++; if (de_out_a !== 1'b1) begin miscompares++; $display("FAIL de_out_d2: got %b expected 1", de_out_a); end
      repeat (1918) @(negedge clk);
      de_a = 0;
      repeat (100) @(negedge clk);
      bad = -1;
      foreach (qa[i]) if (bad < 0 && qa[i] !== 32'(ln * 2048 + i)) bad = i;
      vectors++; if (qa.size() != 1920) begin miscompares++; $display("FAIL pix_count_line%0d: got %0d expected 1920", ln, qa.size()); end
      vectors++; if (bad >= 0) begin miscompares++; $display("FAIL pix_line%0d: index %0d got %0d expected %0d", ln, bad, qa[bad], ln * 2048 + bad); end
      if (ln == 0) begin
        vectors++; if (rq_num_a.size() != 3 || rq_half_a[2] !== 1'b0 || rq_num_a[2] != 2) begin miscompares++; $display("FAIL req2_after_line0: got %0d requests expected 3 (half 0 line 2)", rq_num_a.size()); end
      end
    end
  endtask

  task automatic test_underflow();
    int bad;
    vs_b = 1;
    @(negedge clk);
    vs_b = 0;
    repeat (5) @(negedge clk);
    vectors++; if (rq_num_b.size() != 1 || rq_half_b[0] !== 1'b0 || rq_num_b[0] != 0) begin miscompares++; $display("FAIL b_req0: got %0d requests expected 1 (half 0 line 0)", rq_num_b.size()); end
    qb.delete();
    drive_line_b(8, 0);
    vectors++; if (uf_b !== 1'b1) begin miscompares++; $display("FAIL underflow_set: got %b expected 1", uf_b); end
    bad = -1;
    foreach (qb[i]) if (bad < 0 && qb[i] !== 32'd0) bad = i;
    vectors++; if (qb.size() != 8) begin miscompares++; $display("FAIL uf_de_out_count: got %0d expected 8", qb.size()); end
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL uf_pix_zero: index %0d got %0h expected 0", bad, qb[bad]); end
    pulse_rdy_b();
    @(negedge clk);
    vectors++; if (rq_num_b.size() != 2 || rq_half_b[1] !== 1'b1 || rq_num_b[1] != 1) begin miscompares++; $display("FAIL b_req1: got %0d requests expected 2 (half 1 line 1)", rq_num_b.size()); end
  endtask

  task automatic test_simultaneous();
    int bad;
    qb.delete();
    drive_line_b(8, 1);
    bad = -1;
    foreach (qb[i]) if (bad < 0 && qb[i] !== 32'(i)) bad = i;
    vectors++; if (qb.size() != 8 || bad >= 0) begin miscompares++; $display("FAIL rd_half_kept: got %0d pixels, first bad %0d expected 8 pixels 0..7", qb.size(), bad); end
    vectors++; if (rq_num_b.size() != 3 || rq_half_b[2] !== 1'b0 || rq_num_b[2] != 2) begin miscompares++; $display("FAIL freed_half_req: got %0d requests expected 3 (half 0 line 2)", rq_num_b.size()); end
  endtask

  task automatic test_long_de();
    int bad;
    qb.delete();
    max_lo_b = 0;
    trk_b = 1;
    drive_line_b(10, 0);
    trk_b = 0;
    bad = -1;
    foreach (qb[i]) if (bad < 0 && qb[i] !== ((i < 8) ? 32'(2048 + i) : 32'd0)) bad = i;
    vectors++; if (qb.size() != 10) begin miscompares++; $display("FAIL long_de_count: got %0d expected 10", qb.size()); end
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL long_de_pix: index %0d got %0d expected %0d", bad, qb[bad], (bad < 8) ? 2048 + bad : 0); end
    vectors++; if (max_lo_b > 7) begin miscompares++; $display("FAIL rd_addr_bound: got offset %0d expected <= 7", max_lo_b); end
  endtask

  task automatic test_end_of_frame();
    pulse_rdy_b();
    pulse_rdy_b();
    repeat (10) @(negedge clk);
    vectors++; if (rq_num_b.size() != 4 || rq_half_b[3] !== 1'b1 || rq_num_b[3] != 3) begin miscompares++; $display("FAIL req3: got %0d requests expected 4 (half 1 line 3)", rq_num_b.size()); end
    drive_line_b(8, 0);
    repeat (10) @(negedge clk);
    vectors++; if (rq_num_b.size() != 4) begin miscompares++; $display("FAIL frame_req_limit: got %0d requests expected 4", rq_num_b.size()); end
  endtask

  task automatic test_vs_restart();
    int bad;
    vectors++; if (uf_b !== 1'b1) begin miscompares++; $display("FAIL underflow_sticky: got %b expected 1", uf_b); end
    de_b = 1;
    repeat (3) @(negedge clk);
    vs_b = 1;
    @(negedge clk);
    vs_b = 0; de_b = 0;
    repeat (4) @(negedge clk);
    vectors++; if (uf_b !== 1'b0) begin miscompares++; $display("FAIL underflow_vs_clear: got %b expected 0", uf_b); end
    vectors++; if (rq_num_b.size() != 5 || rq_half_b[4] !== 1'b0 || rq_num_b[4] != 0) begin miscompares++; $display("FAIL restart_req: got %0d requests expected 5 (half 0 line 0)", rq_num_b.size()); end
    pulse_rdy_b();
    @(negedge clk);
    vectors++; if (rq_num_b.size() != 6 || rq_half_b[5] !== 1'b1 || rq_num_b[5] != 1) begin miscompares++; $display("FAIL restart_req1: got %0d requests expected 6 (half 1 line 1)", rq_num_b.size()); end
    qb.delete();
    drive_line_b(8, 0);
    bad = -1;
    foreach (qb[i]) if (bad < 0 && qb[i] !== 32'(i)) bad = i;
    vectors++; if (qb.size() != 8 || bad >= 0) begin miscompares++; $display("FAIL restart_pix: got %0d pixels, first bad %0d expected 8 pixels 0..7", qb.size(), bad); end
  endtask

  initial begin
    test_reset();
    test_prefetch();
    test_hs_delay();
    test_pixel_stream();
    test_underflow();
    test_simultaneous();
    test_long_de();
    test_end_of_frame();
    test_vs_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
